// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetch unit:
// FSM encoding, buffer entry layout and PC increment.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/instr_prefetch_if.sv
// Consumer and SDRAM read-port signals of the prefetch unit.
// The prefetcher takes the slave view; its environment the master view.
interface instr_prefetch_if #(
  parameter int AWIDTH = 25
);
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              fetch_req;
  logic              fetch_ack;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic              sdram_rd_req;
  logic              sdram_rd_ack;
  logic [31:0]       sdram_rd_data;
  logic [AWIDTH-1:0] sdram_addr;

  modport slave (
    input  redirect,
    input  redirect_pc,
    input  fetch_req,
    input  sdram_rd_ack,
    input  sdram_rd_data,
    output fetch_ack,
    output instr,
    output instr_pc,
    output sdram_rd_req,
    output sdram_addr
  );

  modport master (
    output redirect,
    output redirect_pc,
    output fetch_req,
    output sdram_rd_ack,
    output sdram_rd_data,
    input  fetch_ack,
    input  instr,
    input  instr_pc,
    input  sdram_rd_req,
    input  sdram_addr
  );
endinterface

// File: rtl/instr_fifo.sv
// Show-ahead FIFO with synchronous flush; head reads zero when empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module instr_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_q] <= wdata;
  end

  assign rdata = (cnt_q != '0) ? mem[rd_q] : '0;
  assign count = cnt_q;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: streams sequential words from SDRAM into a
// small show-ahead buffer and restarts the stream on redirect.
module instr_prefetch
  import fetch_pkg::*;
#(
  parameter int AWIDTH = 25,
  parameter int DEPTH  = 4
) (
  input logic              CLK,
  input logic              RST_X,
  instr_prefetch_if.slave  bus
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH-1);

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [AWIDTH-1:0] drain_addr_q, drain_addr_d;

  logic         push;
  logic         pop;
  logic         ack;
  logic [CW-1:0] count;
  fetch_entry_t wentry;
  fetch_entry_t head;

  assign ack    = bus.sdram_rd_ack;
  assign pop    = bus.fetch_req & (count != '0) & ~bus.redirect;
  assign push   = (state_q == S_REQ) & ack & ~bus.redirect;
  assign wentry = '{instr: bus.sdram_rd_data, pc: fetch_pc_q};

  instr_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_X),
    .flush (bus.redirect),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .count (count)
  );

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    if (push)         fetch_pc_d = next_pc(fetch_pc_q);
    if (bus.redirect) fetch_pc_d = bus.redirect_pc;
    unique case (state_q)
      S_IDLE: begin
        if (bus.redirect || count < FULL) state_d = S_REQ;
      end
      S_REQ: begin
        // An unacked read is still in flight: finish it at the old address.
        if (bus.redirect) begin
          if (!ack) begin
            state_d      = S_DRAIN;
            drain_addr_d = fetch_pc_q[AWIDTH-1:0];
          end
        end else if (ack && count == LAST && !pop) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (ack) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= '0;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  assign bus.fetch_ack    = pop;
  assign bus.instr        = head.instr;
  assign bus.instr_pc     = head.pc;
  assign bus.sdram_rd_req = (state_q != S_IDLE);
  assign bus.sdram_addr   = (state_q == S_DRAIN) ? drain_addr_q
                                                 : fetch_pc_q[AWIDTH-1:0];

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch with a latency-programmable SDRAM
// responder; data returned for address A is A ^ 32'hA5C30F00.
module tb_instr_prefetch;
  localparam int AW = 25;

  logic clk = 1'b0;
  logic rst_x = 1'b0;
  always #5 clk = ~clk;

  instr_prefetch_if #(.AWIDTH(AW)) bus ();

  instr_prefetch #(
    .AWIDTH (AW),
    .DEPTH  (4)
  ) dut (
    .CLK   (clk),
    .RST_X (rst_x),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int lat   = 2;
  bit hold  = 1'b0;
  int wcnt  = 0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {7'd0, a[AW-1:0]} ^ 32'hA5C3_0F00;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ack in the lat-th cycle of each request; hold freezes it
  always @(negedge clk) begin
    if (!rst_x || !bus.sdram_rd_req) begin
      bus.sdram_rd_ack = 1'b0;
      wcnt = 0;
    end else if (hold) begin
      bus.sdram_rd_ack = 1'b0;
    end else begin
      wcnt++;
      if (wcnt >= lat) begin
        bus.sdram_rd_ack  = 1'b1;
        bus.sdram_rd_data = mdata({7'd0, bus.sdram_addr});
        wcnt = 0;
      end else begin
        bus.sdram_rd_ack = 1'b0;
      end
    end
  end

  typedef struct {
    logic        fr;
    logic        ereq;
    logic [31:0] eaddr;
    logic        eack;
    logic        hv;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[17];

  task automatic do_reset(input int l);
    @(negedge clk);
    rst_x = 1'b0;
    bus.redirect = 1'b0;
    bus.fetch_req = 1'b0;
    hold = 1'b0;
    lat = l;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] first_addr;
    logic [31:0] pcs[2];
    bit found;
    int nack;
    int first_k;

    bus.redirect      = 1'b0;
    bus.redirect_pc   = 32'h0;
    bus.fetch_req     = 1'b0;
    bus.sdram_rd_ack  = 1'b0;
    bus.sdram_rd_data = 32'h0;

    tbl[0]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00};
    tbl[1]  = '{1'b0, 1'b1, 32'h00, 1'b0, 1'b0, 32'h00};
    tbl[2]  = '{1'b0, 1'b1, 32'h00, 1'b0, 1'b0, 32'h00};
    tbl[3]  = '{1'b0, 1'b1, 32'h04, 1'b0, 1'b1, 32'h00};
    tbl[4]  = '{1'b0, 1'b1, 32'h04, 1'b0, 1'b1, 32'h00};
    tbl[5]  = '{1'b0, 1'b1, 32'h08, 1'b0, 1'b1, 32'h00};
    tbl[6]  = '{1'b0, 1'b1, 32'h08, 1'b0, 1'b1, 32'h00};
    tbl[7]  = '{1'b0, 1'b1, 32'h0C, 1'b0, 1'b1, 32'h00};
    tbl[8]  = '{1'b0, 1'b1, 32'h0C, 1'b0, 1'b1, 32'h00};
    tbl[9]  = '{1'b0, 1'b0, 32'h10, 1'b0, 1'b1, 32'h00};
    tbl[10] = '{1'b1, 1'b0, 32'h10, 1'b1, 1'b1, 32'h00};
    tbl[11] = '{1'b1, 1'b0, 32'h10, 1'b1, 1'b1, 32'h04};
    tbl[12] = '{1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 32'h08};
    tbl[13] = '{1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 32'h0C};
    tbl[14] = '{1'b1, 1'b1, 32'h14, 1'b1, 1'b1, 32'h10};
    tbl[15] = '{1'b1, 1'b1, 32'h14, 1'b0, 1'b0, 32'h00};
    tbl[16] = '{1'b1, 1'b1, 32'h18, 1'b1, 1'b1, 32'h14};

    // reset state with fetch_req asserted
    do_reset(2);
    bus.fetch_req = 1'b1;
    #2;
    chk("rst_req", 32'(bus.sdram_rd_req), 32'h0);
    chk("rst_addr", 32'(bus.sdram_addr), 32'h0);
    chk("rst_ack", 32'(bus.fetch_ack), 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pc", bus.instr_pc, 32'h0);

    // fill then drain, ack latency 2
    do_reset(2);
    @(negedge clk);
    rst_x = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) @(negedge clk);
      bus.fetch_req = tbl[i].fr;
      #2;
      chk($sformatf("c%0d_req", i), 32'(bus.sdram_rd_req), 32'(tbl[i].ereq));
      chk($sformatf("c%0d_addr", i), 32'(bus.sdram_addr), tbl[i].eaddr);
      chk($sformatf("c%0d_ack", i), 32'(bus.fetch_ack), 32'(tbl[i].eack));
      chk($sformatf("c%0d_pc", i), bus.instr_pc,
          tbl[i].hv ? tbl[i].epc : 32'h0);
      chk($sformatf("c%0d_instr", i), bus.instr,
          tbl[i].hv ? mdata(tbl[i].epc) : 32'h0);
    end
    bus.fetch_req = 1'b0;

    // full buffer, fetch_req held, latency 1: no gaps
    do_reset(1);
    @(negedge clk);
    rst_x = 1'b1;
    repeat (20) @(negedge clk);
    #2;
    chk("full_req", 32'(bus.sdram_rd_req), 32'h0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      bus.fetch_req = 1'b1;
      #2;
      exp_pc = 32'(k * 4);
      chk($sformatf("strm%0d_ack", k), 32'(bus.fetch_ack), 32'h1);
      chk($sformatf("strm%0d_pc", k), bus.instr_pc, exp_pc);
      chk($sformatf("strm%0d_in", k), bus.instr, mdata(exp_pc));
    end
    bus.fetch_req = 1'b0;

    // redirect while read of 0x8 pending -> drain
    do_reset(2);
    @(negedge clk);
    rst_x = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      #2;
      if (bus.sdram_rd_req && bus.sdram_addr == 25'h8) found = 1'b1;
    end
    chk("drn_find8", 32'(found), 32'h1);
    hold = 1'b1;
    @(negedge clk);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    bus.fetch_req = 1'b1;
    #2;
    chk("drn_redir_ack", 32'(bus.fetch_ack), 32'h0);
    @(negedge clk);
    bus.redirect = 1'b0;
    #2;
    chk("drn_req", 32'(bus.sdram_rd_req), 32'h1);
    chk("drn_oldaddr", 32'(bus.sdram_addr), 32'h8);
    chk("drn_empty", bus.instr, 32'h0);
    hold = 1'b0;
    found = 1'b0;
    first_addr = 32'hFFFF_FFFF;
    exp_pc = 32'hFFFF_FFFF;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      #2;
      if (bus.sdram_addr != 25'h8 && first_addr == 32'hFFFF_FFFF)
        first_addr = 32'(bus.sdram_addr);
      if (bus.fetch_ack) begin
        found = 1'b1;
        exp_pc = bus.instr_pc;
        chk("drn_instr", bus.instr, mdata(32'h100));
      end
    end
    chk("drn_newaddr", first_addr, 32'h100);
    chk("drn_firstpc", exp_pc, 32'h100);
    bus.fetch_req = 1'b0;

    // redirect + fetch_req with two entries buffered
    do_reset(1);
    @(negedge clk);
    rst_x = 1'b1;
    nack = 0;
    for (int k = 0; k < 20 && nack < 2; k++) begin
      @(negedge clk);
      #2;
      if (bus.sdram_rd_ack) nack++;
    end
    chk("cnt2_acks", 32'(nack), 32'h2);
    hold = 1'b1;
    @(negedge clk);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    bus.fetch_req = 1'b1;
    #2;
    chk("cnt2_head", bus.instr, mdata(32'h0));
    chk("cnt2_ack", 32'(bus.fetch_ack), 32'h0);
    @(negedge clk);
    bus.redirect = 1'b0;
    #2;
    chk("cnt2_flush_ack", 32'(bus.fetch_ack), 32'h0);
    chk("cnt2_flush_in", bus.instr, 32'h0);
    bus.fetch_req = 1'b0;
    hold = 1'b0;

    // wrap past 0xFFFFFFFC and redirect-to-ack latency
    do_reset(1);
    @(negedge clk);
    rst_x = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    bus.fetch_req = 1'b1;
    #2;
    chk("wrap_ack0", 32'(bus.fetch_ack), 32'h0);
    nack = 0;
    first_k = -1;
    pcs[0] = 32'h1;
    pcs[1] = 32'h1;
    for (int k = 1; k < 20 && nack < 2; k++) begin
      @(negedge clk);
      bus.redirect = 1'b0;
      #2;
      if (k == 1) chk("wrap_addr", 32'(bus.sdram_addr), 32'h1FF_FFFC);
      if (bus.fetch_ack) begin
        if (nack == 0) begin
          first_k = k;
          chk("wrap_instr", bus.instr, mdata(32'hFFFF_FFFC));
        end
        pcs[nack] = bus.instr_pc;
        nack++;
      end
    end
    chk("wrap_lat", 32'(first_k), 32'd2);
    chk("wrap_pc0", pcs[0], 32'hFFFF_FFFC);
    chk("wrap_pc1", pcs[1], 32'h0);
    bus.fetch_req = 1'b0;

    // asynchronous reset mid-request
    do_reset(3);
    @(negedge clk);
    rst_x = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      #2;
      if (bus.sdram_rd_req && bus.sdram_addr == 25'h4) found = 1'b1;
    end
    chk("arst_find4", 32'(found), 32'h1);
    #1;
    bus.fetch_req = 1'b1;
    rst_x = 1'b0;
    #1;
    chk("arst_req", 32'(bus.sdram_rd_req), 32'h0);
    chk("arst_addr", 32'(bus.sdram_addr), 32'h0);
    chk("arst_ack", 32'(bus.fetch_ack), 32'h0);
    chk("arst_instr", bus.instr, 32'h0);
    @(negedge clk);
    rst_x = 1'b1;
    bus.fetch_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      #2;
      if (bus.sdram_rd_req) begin
        found = 1'b1;
        chk("arst_first", 32'(bus.sdram_addr), 32'h0);
      end
    end
    chk("arst_rereq", 32'(found), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Parameter AWIDTH, default 25, SHALL set the SDRAM address width.
REQ-002 Parameter DEPTH, default 4, SHALL set the prefetch buffer depth; legal values are powers of two, 2..16.
REQ-003 CLK  in  1  single clock; all state changes on posedge CLK.
REQ-004 RST_X  in  1  reset, asynchronous, active-low.
REQ-005 redirect  in  1  one-cycle pulse; restart fetch at redirect_pc.
REQ-006 redirect_pc  in  32  new byte address of the fetch stream.
REQ-007 fetch_req  in  1  consumer requests one instruction.
REQ-008 fetch_ack  out  1  instr/instr_pc valid and consumed this cycle.
REQ-009 instr  out  32  instruction word at the buffer head.
REQ-010 instr_pc  out  32  byte address of instr.
REQ-011 sdram_rd_req  out  1  read request, held until acknowledged.
REQ-012 sdram_rd_ack  in  1  read complete; sdram_rd_data valid this cycle.
REQ-013 sdram_rd_data  in  32  read data.
REQ-014 sdram_addr  out  AWIDTH  read address = fetch_pc[AWIDTH-1:0].

Function
REQ-015 The block SHALL hold fetch_pc (32 b), a DEPTH-entry FIFO of {instr, pc} pairs, count (0..DEPTH) and a 2-state-bit FSM: IDLE, REQ, DRAIN.
REQ-016 IDLE -> REQ when count + pending < DEPTH and no redirect this cycle, where pending = 1 only in REQ; a full buffer SHALL hold IDLE.
REQ-017 REQ SHALL drive sdram_rd_req=1 with sdram_addr stable until the cycle sdram_rd_ack=1.
REQ-018 On ack in REQ: push {sdram_rd_data, fetch_pc}, fetch_pc += 4 (mod 2^32), next state REQ if free space remains after the push and pop of that cycle, else IDLE; back-to-back requests SHALL incur no idle cycle.
REQ-019 fetch_ack SHALL be combinational: fetch_req & (count != 0) & ~redirect; instr/instr_pc show the head entry (show-ahead), popped on fetch_ack.
REQ-020 When count == 0, instr and instr_pc SHALL read 32'h0 and fetch_ack SHALL be 0; a word pushed at edge t is ackable from cycle t+1 (no bypass).
REQ-021 Simultaneous push and pop SHALL leave count unchanged; push at count == DEPTH SHALL be impossible by REQ-016.
REQ-022 redirect SHALL at the next edge empty the FIFO (count=0), load fetch_pc = redirect_pc, and override a same-cycle push and pop.
REQ-023 redirect in IDLE -> REQ; redirect in REQ with ack the same cycle -> REQ (returned data discarded); redirect in REQ without ack -> DRAIN.
REQ-024 DRAIN SHALL keep sdram_rd_req=1 and the old address until ack, discard the data, then -> REQ at the new fetch_pc; a further redirect in DRAIN only updates fetch_pc.
REQ-025 redirect_pc low bits SHALL be used unmodified; alignment is the consumer's duty.
REQ-026 Latency: redirect at edge t -> sdram_rd_req at t+1 -> with ack in cycle t+1+k, fetch_ack possible in cycle t+2+k.

Reset
REQ-027 While RST_X=0: state IDLE, count 0, fetch_pc 0, sdram_rd_req 0, fetch_ack 0, instr 0, instr_pc 0, sdram_addr 0.
REQ-028 Reset asserted mid-request SHALL abandon it; the first request after release is at address 0.

Structure
REQ-029 State encodings and PC_STEP=4 SHALL live in shared package fetch_pkg.
REQ-030 FIFO storage, pointers and count SHALL be sub-module instr_fifo (params WIDTH=64, DEPTH) with flush input.

Verification
REQ-031 Reset release, ack latency 2, no fetch_req -> reads at 0x0,0x4,0x8,0xC then sdram_rd_req stays 0 (buffer full, DEPTH=4).
REQ-032 Full buffer, fetch_req held -> fetch_ack every cycle once refilling, instr_pc 0x0,0x4,... contiguous, no gaps.
REQ-033 redirect to 0x100 while REQ pending at 0x8 -> DRAIN, data of 0x8 never delivered, next sdram_addr 0x100, first instr_pc 0x100.
REQ-034 redirect and fetch_req same cycle with count=2 -> fetch_ack 0, count 0 next cycle.
REQ-035 redirect_pc 0xFFFFFFFC -> instr_pc 0xFFFFFFFC then 0x00000000 (wrap).
REQ-036 RST_X low while sdram_rd_req=1 -> outputs 0 asynchronously; after release first sdram_addr 0.
